// File: rtl/mannix_sw_ctrl.sv
// Software control/status register bank for the mannix FCC and activation units:
// job parameters, go pulses, per-unit busy/done tracking, result capture and irq.
module mannix_sw_ctrl #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reg_wr_en,
   input  logic                  reg_rd_en,
   input  logic [REG_ADDR_W-1:0] reg_addr,
   input  logic [DATA_W-1:0]     reg_wdata,
   output logic [DATA_W-1:0]     reg_rdata,
   output logic                  reg_rd_valid,
   output logic [DATA_W-1:0]     fc_addrx,
   output logic [DATA_W-1:0]     fc_addry,
   output logic [DATA_W-1:0]     fc_addrb,
   output logic [DATA_W-1:0]     fc_xm,
   output logic [DATA_W-1:0]     fc_ym,
   output logic [DATA_W-1:0]     fc_yn,
   output logic [DATA_W-1:0]     cnn_bn,
   output logic                  fc_go,
   input  logic                  fc_done,
   input  logic [DATA_W-1:0]     fc_addrz,
   output logic [DATA_W-1:0]     activ_addrx,
   output logic [DATA_W-1:0]     activ_xm,
   output logic [DATA_W-1:0]     activ_ym,
   output logic                  activ_go,
   input  logic                  activ_done,
   input  logic [DATA_W-1:0]     activ_addrz,
   input  logic                  pool_busy,
   input  logic                  cnn_busy,
   output logic                  irq
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [REG_ADDR_W-1:0] ADDR_CTRL        = REG_ADDR_W'(6'h00);
   localparam logic [REG_ADDR_W-1:0] ADDR_STATUS      = REG_ADDR_W'(6'h01);
   localparam logic [REG_ADDR_W-1:0] ADDR_IRQ_EN      = REG_ADDR_W'(6'h02);
   localparam logic [REG_ADDR_W-1:0] ADDR_FC_ZADDR    = REG_ADDR_W'(6'h03);
   localparam logic [REG_ADDR_W-1:0] ADDR_ACTIV_ZADDR = REG_ADDR_W'(6'h04);
   localparam logic [REG_ADDR_W-1:0] ADDR_FC_FIRST    = REG_ADDR_W'(6'h08);
   localparam logic [REG_ADDR_W-1:0] ADDR_FC_LAST     = REG_ADDR_W'(6'h0E);
   localparam logic [REG_ADDR_W-1:0] ADDR_ACTIV_FIRST = REG_ADDR_W'(6'h10);
   localparam logic [REG_ADDR_W-1:0] ADDR_ACTIV_LAST  = REG_ADDR_W'(6'h12);

   // Sticky vector layout: [0] fc_done [1] activ_done [2] fc_go_err
   // [3] activ_go_err [4] fc_cfg_err [5] activ_cfg_err
   logic [DATA_W-1:0] fc_prm_q    [7];
   logic [DATA_W-1:0] fc_prm_d    [7];
   logic [DATA_W-1:0] activ_prm_q [3];
   logic [DATA_W-1:0] activ_prm_d [3];
   logic [0:0]        fc_state_q, fc_state_d;
   logic [0:0]        activ_state_q, activ_state_d;
   logic              fc_go_q, fc_go_d;
   logic              activ_go_q, activ_go_d;
   logic [DATA_W-1:0] fc_zaddr_q, fc_zaddr_d;
   logic [DATA_W-1:0] activ_zaddr_q, activ_zaddr_d;
   logic [5:0]        sticky_q, sticky_d;
   logic [1:0]        irq_en_q, irq_en_d;
   logic              irq_q, irq_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rd_valid_q;

   logic              fc_busy_s, activ_busy_s;
   logic              wr_ctrl_s, wr_status_s;
   logic              fc_prm_wr_s, activ_prm_wr_s;
   logic              fc_go_req_s, activ_go_req_s;
   logic              fc_done_acc_s, activ_done_acc_s;
   logic [5:0]        sticky_set_s, sticky_clr_s;
   logic [DATA_W-1:0] status_s;

   assign fc_busy_s      = (fc_state_q == ST_BUSY);
   assign activ_busy_s   = (activ_state_q == ST_BUSY);
   assign wr_ctrl_s      = reg_wr_en && (reg_addr == ADDR_CTRL);
   assign wr_status_s    = reg_wr_en && (reg_addr == ADDR_STATUS);
   assign fc_prm_wr_s    = reg_wr_en && (reg_addr >= ADDR_FC_FIRST) && (reg_addr <= ADDR_FC_LAST);
   assign activ_prm_wr_s = reg_wr_en && (reg_addr >= ADDR_ACTIV_FIRST) && (reg_addr <= ADDR_ACTIV_LAST);
   assign fc_go_req_s    = wr_ctrl_s && reg_wdata[0];
   assign activ_go_req_s = wr_ctrl_s && reg_wdata[1];
   // A done coinciding with the go pulse belongs to a previous job and is ignored.
   assign fc_done_acc_s    = fc_busy_s && fc_done && !fc_go_q;
   assign activ_done_acc_s = activ_busy_s && activ_done && !activ_go_q;

   // Per-unit FSMs, go pulses and result address capture.
   always_comb begin
      fc_state_d    = fc_state_q;
      activ_state_d = activ_state_q;
      fc_go_d       = 1'b0;
      activ_go_d    = 1'b0;
      case (fc_state_q)
         ST_IDLE: begin
            if (fc_go_req_s) begin
               fc_state_d = ST_BUSY;
               fc_go_d    = 1'b1;
            end else begin
               fc_state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (fc_done_acc_s) begin
               fc_state_d = ST_IDLE;
            end else begin
               fc_state_d = ST_BUSY;
            end
         end
         default: fc_state_d = ST_IDLE;
      endcase
      case (activ_state_q)
         ST_IDLE: begin
            if (activ_go_req_s) begin
               activ_state_d = ST_BUSY;
               activ_go_d    = 1'b1;
            end else begin
               activ_state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (activ_done_acc_s) begin
               activ_state_d = ST_IDLE;
            end else begin
               activ_state_d = ST_BUSY;
            end
         end
         default: activ_state_d = ST_IDLE;
      endcase
      fc_zaddr_d    = fc_done_acc_s ? fc_addrz : fc_zaddr_q;
      activ_zaddr_d = activ_done_acc_s ? activ_addrz : activ_zaddr_q;
   end

   // Parameter writes, accepted only while the owning unit is idle.
   always_comb begin
      fc_prm_d    = fc_prm_q;
      activ_prm_d = activ_prm_q;
      if (fc_prm_wr_s && !fc_busy_s) begin
         fc_prm_d[reg_addr[2:0]] = reg_wdata;
      end else begin
         fc_prm_d = fc_prm_q;
      end
      if (activ_prm_wr_s && !activ_busy_s) begin
         activ_prm_d[reg_addr[1:0]] = reg_wdata;
      end else begin
         activ_prm_d = activ_prm_q;
      end
   end

   // Sticky status bits (set wins over W1C), IRQ enable and interrupt level.
   always_comb begin
      sticky_set_s = {activ_prm_wr_s && activ_busy_s,
                      fc_prm_wr_s && fc_busy_s,
                      activ_go_req_s && activ_busy_s,
                      fc_go_req_s && fc_busy_s,
                      activ_done_acc_s,
                      fc_done_acc_s};
      if (wr_status_s) begin
         sticky_clr_s = {reg_wdata[19], reg_wdata[18], reg_wdata[17],
                         reg_wdata[16], reg_wdata[9], reg_wdata[8]};
      end else begin
         sticky_clr_s = 6'b000000;
      end
      sticky_d = (sticky_q & ~sticky_clr_s) | sticky_set_s;
      if (reg_wr_en && (reg_addr == ADDR_IRQ_EN)) begin
         irq_en_d = reg_wdata[1:0];
      end else begin
         irq_en_d = irq_en_q;
      end
      irq_d = |(sticky_q[1:0] & irq_en_q);
   end

   // Read mux; samples pre-write state so a same-cycle write is not visible.
   always_comb begin
      status_s     = '0;
      status_s[0]  = fc_busy_s;
      status_s[1]  = activ_busy_s;
      status_s[2]  = pool_busy;
      status_s[3]  = cnn_busy;
      status_s[8]  = sticky_q[0];
      status_s[9]  = sticky_q[1];
      status_s[16] = sticky_q[2];
      status_s[17] = sticky_q[3];
      status_s[18] = sticky_q[4];
      status_s[19] = sticky_q[5];
      rdata_d      = '0;
      if (reg_rd_en) begin
         case (reg_addr)
            ADDR_STATUS:        rdata_d = status_s;
            ADDR_IRQ_EN:        rdata_d = {{(DATA_W-2){1'b0}}, irq_en_q};
            ADDR_FC_ZADDR:      rdata_d = fc_zaddr_q;
            ADDR_ACTIV_ZADDR:   rdata_d = activ_zaddr_q;
            REG_ADDR_W'(6'h08): rdata_d = fc_prm_q[0];
            REG_ADDR_W'(6'h09): rdata_d = fc_prm_q[1];
            REG_ADDR_W'(6'h0A): rdata_d = fc_prm_q[2];
            REG_ADDR_W'(6'h0B): rdata_d = fc_prm_q[3];
            REG_ADDR_W'(6'h0C): rdata_d = fc_prm_q[4];
            REG_ADDR_W'(6'h0D): rdata_d = fc_prm_q[5];
            REG_ADDR_W'(6'h0E): rdata_d = fc_prm_q[6];
            REG_ADDR_W'(6'h10): rdata_d = activ_prm_q[0];
            REG_ADDR_W'(6'h11): rdata_d = activ_prm_q[1];
            REG_ADDR_W'(6'h12): rdata_d = activ_prm_q[2];
            default:            rdata_d = '0;
         endcase
      end else begin
         rdata_d = '0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 7; i++) fc_prm_q[i] <= '0;
         for (int i = 0; i < 3; i++) activ_prm_q[i] <= '0;
         fc_state_q    <= ST_IDLE;
         activ_state_q <= ST_IDLE;
         fc_go_q       <= 1'b0;
         activ_go_q    <= 1'b0;
         fc_zaddr_q    <= '0;
         activ_zaddr_q <= '0;
         sticky_q      <= 6'b000000;
         irq_en_q      <= 2'b00;
         irq_q         <= 1'b0;
         rdata_q       <= '0;
         rd_valid_q    <= 1'b0;
      end else begin
         fc_prm_q      <= fc_prm_d;
         activ_prm_q   <= activ_prm_d;
         fc_state_q    <= fc_state_d;
         activ_state_q <= activ_state_d;
         fc_go_q       <= fc_go_d;
         activ_go_q    <= activ_go_d;
         fc_zaddr_q    <= fc_zaddr_d;
         activ_zaddr_q <= activ_zaddr_d;
         sticky_q      <= sticky_d;
         irq_en_q      <= irq_en_d;
         irq_q         <= irq_d;
         rdata_q       <= rdata_d;
         rd_valid_q    <= reg_rd_en;
      end
   end

   assign fc_addrx     = fc_prm_q[0];
   assign fc_addry     = fc_prm_q[1];
   assign fc_addrb     = fc_prm_q[2];
   assign fc_xm        = fc_prm_q[3];
   assign fc_ym        = fc_prm_q[4];
   assign fc_yn        = fc_prm_q[5];
   assign cnn_bn       = fc_prm_q[6];
   assign activ_addrx  = activ_prm_q[0];
   assign activ_xm     = activ_prm_q[1];
   assign activ_ym     = activ_prm_q[2];
   assign fc_go        = fc_go_q;
   assign activ_go     = activ_go_q;
   assign irq          = irq_q;
   assign reg_rdata    = rdata_q;
   assign reg_rd_valid = rd_valid_q;

endmodule
